// File: rtl/pwm_capture.sv
// pwm_capture: recovers signed duty, period and fault status
// from a PWM/direction triple; one publish per PWM period.
module pwm_capture #(
  parameter int TIMEOUT    = 65535,
  parameter int FULL_SCALE = 10000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwm_in,
  input  logic               dir_a_in,
  input  logic               dir_b_in,
  output logic signed [31:0] duty_out,
  output logic        [31:0] period_out,
  output logic               sample_valid,
  output logic               signal_lost,
  output logic               dir_fault
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic [31:0] FS = 32'(FULL_SCALE);

  typedef enum logic [1:0] {
    WAIT_RISE,
    HIGH,
    LOW
  } state_t;

  state_t        state;
  logic [1:0]    pwm_sync;
  logic [1:0]    a_sync;
  logic [1:0]    b_sync;
  logic          pwm_d;
  logic [1:0]    warm;
  logic [1:0]    dir_lat;
  logic [CW-1:0] period_cnt;
  logic [CW-1:0] high_cnt;

  logic       pwm_s;
  logic [1:0] dir_s;
  logic       rise;
  logic       fall;
  logic       tmo;

  assign pwm_s = pwm_sync[1];
  assign dir_s = {a_sync[1], b_sync[1]};
  // Edge detect is held off until pwm_d carries a real sample,
  // so a line already high at reset release is not a rise.
  assign rise  = (warm == 2'd3) && pwm_s && !pwm_d;
  assign fall  = !pwm_s && pwm_d;
  assign tmo   = (period_cnt == TMAX);

  function automatic logic [31:0] signed_mag(
    input logic [1:0]  dir,
    input logic [31:0] mag
  );
    logic [31:0] r;
    r = '0;
    unique case (dir)
      2'b10:   r = mag;
      2'b01:   r = -mag;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_sync <= '0;
      a_sync   <= '0;
      b_sync   <= '0;
      pwm_d    <= 1'b0;
      warm     <= '0;
    end else begin
      pwm_sync <= {pwm_sync[0], pwm_in};
      a_sync   <= {a_sync[0], dir_a_in};
      b_sync   <= {b_sync[0], dir_b_in};
      pwm_d    <= pwm_s;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_RISE;
      period_cnt   <= '0;
      high_cnt     <= '0;
      dir_lat      <= '0;
      duty_out     <= '0;
      period_out   <= '0;
      sample_valid <= 1'b0;
      signal_lost  <= 1'b0;
      dir_fault    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!tmo) period_cnt <= period_cnt + 1'b1;
      if (state == HIGH && !fall && high_cnt != TMAX)
        high_cnt <= high_cnt + 1'b1;

      if (rise) begin
        state      <= HIGH;
        period_cnt <= CW'(1);
        high_cnt   <= CW'(1);
        dir_lat    <= dir_s;
        if (state == LOW) begin
          duty_out     <= signed_mag(dir_lat, 32'(high_cnt));
          period_out   <= 32'(period_cnt);
          dir_fault    <= &dir_lat;
          signal_lost  <= 1'b0;
          sample_valid <= 1'b1;
        end
      end else if (tmo) begin
        state        <= WAIT_RISE;
        period_cnt   <= CW'(1);
        duty_out     <= pwm_s ? signed_mag(dir_s, FS) : '0;
        dir_fault    <= pwm_s && (&dir_s);
        period_out   <= '0;
        signal_lost  <= 1'b1;
        sample_valid <= 1'b1;
      end else if (state == HIGH && fall) begin
        state <= LOW;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture; expected
// samples are queued as PWM periods are driven.
module tb_pwm_capture;

  localparam int TO = 2000;
  localparam int FS = 10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm = 1'b0;
  logic da = 1'b0;
  logic db = 1'b0;
  logic signed [31:0] duty;
  logic [31:0] period;
  logic sv;
  logic lost;
  logic fault;

  always #5 clk = ~clk;

  pwm_capture #(.TIMEOUT(TO), .FULL_SCALE(FS)) dut (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm),
    .dir_a_in(da),
    .dir_b_in(db),
    .duty_out(duty),
    .period_out(period),
    .sample_valid(sv),
    .signal_lost(lost),
    .dir_fault(fault)
  );

  typedef struct {
    logic [31:0] duty;
    logic [31:0] period;
    logic        lost;
    logic        fault;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int passes = 0;
  int total = 0;
  logic last_sv = 1'b0;

  bit prev_valid = 0;
  logic [1:0] prev_dir = 2'b00;
  int prev_high = 0;
  int prev_per = 0;

  function automatic logic [31:0] model_duty(input logic [1:0] d, input int mag);
    if (d == 2'b10) return 32'(mag);
    if (d == 2'b01) return 32'(-mag);
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    #1;
    if (sv) begin
      total++;
      if (last_sv) $display("FAIL pulse_width: sample_valid high two cycles");
      else passes++;
      total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_publish: duty=%0d period=%0d lost=%b fault=%b",
                 duty, period, lost, fault);
      end else begin
        mon_e = q.pop_front();
        if (duty !== mon_e.duty || period !== mon_e.period ||
            lost !== mon_e.lost || fault !== mon_e.fault)
          $display("FAIL sample: got duty=%0d period=%0d lost=%b fault=%b, want duty=%0d period=%0d lost=%b fault=%b",
                   duty, period, lost, fault, $signed(mon_e.duty),
                   mon_e.period, mon_e.lost, mon_e.fault);
        else passes++;
      end
    end
    last_sv = sv;
  end

  task automatic push_prev();
    exp_t e;
    if (prev_valid) begin
      e.duty = model_duty(prev_dir, prev_high);
      e.period = 32'(prev_per);
      e.lost = 1'b0;
      e.fault = (prev_dir == 2'b11);
      q.push_back(e);
    end
  endtask

  task automatic run_period(input logic [1:0] dir, input int hi,
                            input int per, input logic [1:0] mid_dir);
    bit pub;
    pub = prev_valid;
    push_prev();
    pwm = 1'b1;
    {da, db} = dir;
    for (int i = 0; i < hi; i++) begin
      if (i == 2 && pub) begin
        @(posedge clk);
        #1;
        total++;
        if (sv !== 1'b1) $display("FAIL latency: sample_valid=%b want 1", sv);
        else passes++;
      end
      @(negedge clk);
      if (i == hi / 2) {da, db} = mid_dir;
    end
    pwm = 1'b0;
    repeat (per - hi) @(negedge clk);
    prev_valid = 1;
    prev_dir = dir;
    prev_high = hi;
    prev_per = per;
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while (q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) $display("FAIL %s: pending=%0d want 0", name, q.size());
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (duty !== 32'sd0) $display("FAIL reset_duty: %0d want 0", duty); else passes++;
    if (period !== 32'd0) $display("FAIL reset_period: %0d want 0", period); else passes++;
    if (sv !== 1'b0) $display("FAIL reset_valid: %b want 0", sv); else passes++;
    if (lost !== 1'b0) $display("FAIL reset_lost: %b want 0", lost); else passes++;
    if (fault !== 1'b0) $display("FAIL reset_fault: %b want 0", fault); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_stuck_low();
    exp_t e;
    {da, db} = 2'b00;
    pwm = 1'b0;
    e.duty = 32'd0;
    e.period = 32'd0;
    e.lost = 1'b1;
    e.fault = 1'b0;
    q.push_back(e);
    drain("stuck_low_timeout", TO + 50);
    total++;
    if (lost !== 1'b1) $display("FAIL stuck_low_lost: %b want 1", lost);
    else passes++;
    prev_valid = 0;
  endtask

  task automatic test_forward();
    run_period(2'b10, 250, 1000, 2'b10);
    run_period(2'b10, 250, 1000, 2'b01);
    run_period(2'b10, 250, 1000, 2'b10);
    total++;
    if (lost !== 1'b0) $display("FAIL forward_lost_clear: %b want 0", lost);
    else passes++;
  endtask

  task automatic test_reverse();
    run_period(2'b01, 700, 1000, 2'b01);
    run_period(2'b01, 700, 1000, 2'b01);
  endtask

  task automatic test_dir_fault();
    run_period(2'b11, 500, 1000, 2'b11);
    run_period(2'b10, 500, 1000, 2'b10);
    total++;
    if (fault !== 1'b1) $display("FAIL dir_fault_set: %b want 1", fault);
    else passes++;
    run_period(2'b10, 300, 800, 2'b10);
    total++;
    if (fault !== 1'b0) $display("FAIL dir_fault_clear: %b want 0", fault);
    else passes++;
  endtask

  task automatic test_stuck_high();
    exp_t e;
    push_prev();
    prev_valid = 0;
    e.duty = 32'(FS);
    e.period = 32'd0;
    e.lost = 1'b1;
    e.fault = 1'b0;
    q.push_back(e);
    q.push_back(e);
    pwm = 1'b1;
    {da, db} = 2'b10;
    repeat (TO + 10) @(negedge clk);
    total++;
    if (lost !== 1'b1) $display("FAIL stuck_high_lost: %b want 1", lost);
    else passes++;
    repeat (TO) @(negedge clk);
    pwm = 1'b0;
    repeat (50) @(negedge clk);
    drain("stuck_high_repeat", 10);
    run_period(2'b10, 400, 900, 2'b10);
    run_period(2'b10, 123, 600, 2'b10);
    total++;
    if (lost !== 1'b0) $display("FAIL stuck_high_recover: %b want 0", lost);
    else passes++;
  endtask

  task automatic test_reset_mid_high();
    push_prev();
    prev_valid = 0;
    pwm = 1'b1;
    {da, db} = 2'b10;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 5;
    if (duty !== 32'sd0) $display("FAIL rst_mid_duty: %0d want 0", duty); else passes++;
    if (period !== 32'd0) $display("FAIL rst_mid_period: %0d want 0", period); else passes++;
    if (sv !== 1'b0) $display("FAIL rst_mid_valid: %b want 0", sv); else passes++;
    if (lost !== 1'b0) $display("FAIL rst_mid_lost: %b want 0", lost); else passes++;
    if (fault !== 1'b0) $display("FAIL rst_mid_fault: %b want 0", fault); else passes++;
    repeat (100) @(negedge clk);
    pwm = 1'b0;
    repeat (300) @(negedge clk);
    run_period(2'b10, 321, 777, 2'b10);
    run_period(2'b10, 50, 200, 2'b10);
    drain("rst_mid_publish", 10);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stuck_low();
    test_forward();
    test_reverse();
    test_dir_fault();
    test_stuck_high();
    test_reset_mid_high();
    drain("final_queue", 20);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
